// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first W-bit subtractor, optional signed overflow via SERIAL_SUB_OVF_EN
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] D,
  output logic         BOUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         OVF
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic          br;
  logic [CW-1:0] cnt;

  logic          a_bit;
  logic          b_bit;
  logic          d_bit;
  logic          b_nxt;
  logic          last_bit;
  logic [W-1:0]  d_shift;

  // Status flags come straight from the state register.
  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_FIN);

  // One full-subtractor cell plus the next value of the right-shifting result.
  always_comb begin
    a_bit          = sa[0];
    b_bit          = sb[0];
    d_bit          = a_bit ^ b_bit ^ br;
    b_nxt          = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last_bit       = (cnt == CW'(W - 1));
    d_shift        = D >> 1;
    d_shift[W-1]   = d_bit;
  end

  // Handshake FSM, operand shift registers, borrow and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      BOUT  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            sa    <= A;
            sb    <= B;
            br    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          D   <= d_shift;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= b_nxt;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            BOUT  <= b_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // Operand signs differ and the result sign differs from the minuend.
            OVF   <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
